mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous memory between two requesters: port 0 (CPU fetch/data path) and port 1 (loader/debug master).
- Performs at most one access per cycle using a req/gnt handshake.
- Arbitration is round-robin, with an optional bounded lock for bursts.
- Sits between the requesters and memory_module; drives its read, write, addr and data_in pins.

---
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port round-robin arbiter with bounded lock for a single-port sync memory; MEM_ARB_FIXED_PRIO_EN pins priority to port 0
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_HOLD   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic                  p0_lock,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_gnt,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic                  p1_lock,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_gnt,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t state, state_nxt, own_g;
   logic rr_ptr, rr_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [1:0] rd_pend, rd_nxt;
   logic r0, r1, any, g, we_g, lock_g;
   logic [ADDR_WIDTH-1:0] addr_g;
   logic [DATA_WIDTH-1:0] wdata_g;
   assign r0  = p0_req & rst_n;
   assign r1  = p1_req & rst_n;
   assign any = r0 | r1;
   // pick the granted port: owner keeps it until the other side has waited MAX_HOLD grants
   always_comb begin
      g = (r0 & r1) ? rr_ptr : r1;
      if (state == OWN0 && r0) g = r1 && hold_cnt >= HOLD_MAX;
      if (state == OWN1 && r1) g = !(r0 && hold_cnt >= HOLD_MAX);
   end
   assign we_g    = g ? p1_we : p0_we;
   assign lock_g  = g ? p1_lock : p0_lock;
   assign addr_g  = g ? p1_addr : p0_addr;
   assign wdata_g = g ? p1_wdata : p0_wdata;
   assign own_g   = g ? OWN1 : OWN0;
   assign p0_gnt      = any & ~g;
   assign p1_gnt      = any & g;
   assign mem_read    = any & ~we_g;
   assign mem_write   = any & we_g;
   assign mem_addr    = any ? addr_g : '0;
   assign mem_data_in = (any & we_g) ? wdata_g : '0;
   assign p0_rvalid = rd_pend[0];
   assign p1_rvalid = rd_pend[1];
   assign p0_rdata  = rd_pend[0] ? mem_data_out : '0;
   assign p1_rdata  = rd_pend[1] ? mem_data_out : '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
   assign rr_nxt = 1'b0;
`else
   assign rr_nxt = any ? ~g : rr_ptr;
`endif
   // ownership, hold counter and read-pending bookkeeping for the next cycle
   always_comb begin
      state_nxt = (any & lock_g) ? own_g : IDLE;
      hold_nxt  = !(any & lock_g) ? '0 : (state != own_g) ? HW'(1) : (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
      rd_nxt    = {any & g & ~we_g, any & ~g & ~we_g};
   end
   // state registers, cleared asynchronously so a read in flight never reports
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= 1'b0;
         hold_cnt <= '0;
         rd_pend  <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         hold_cnt <= hold_nxt;
         rd_pend  <= rd_nxt;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a behavioural sync memory
module tb_mem_port_arbiter;
   localparam int AW = 5;
   localparam int DW = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic p0_req = 0, p0_we = 0, p0_lock = 0, p1_req = 0, p1_we = 0, p1_lock = 0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
   logic p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_read, mem_write;
   logic [DW-1:0] p0_rdata, p1_rdata, mem_data_in;
   logic [DW-1:0] mem_data_out = '0;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem [32];
   logic [DW-1:0] ref_mem [32];
   typedef struct {logic p; logic [DW-1:0] d;} rd_t;
   rd_t q[$];
   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_data_in;
      if (mem_read) mem_data_out <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic set_p0(input logic r, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
      p0_req = r; p0_we = w; p0_lock = l; p0_addr = a; p0_wdata = d;
   endtask

   task automatic set_p1(input logic r, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
      p1_req = r; p1_we = w; p1_lock = l; p1_addr = a; p1_wdata = d;
   endtask

   task automatic step(input logic [1:0] eg);
      rd_t e;
      logic g, any, we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [1:0] erv;
      logic [1:0][DW-1:0] erd;
      @(negedge clk);
      if (!rst_n) q.delete();
      erv = '0;
      erd = '0;
      if (q.size() > 0) begin
         e = q.pop_front();
         erv[e.p] = 1'b1;
         erd[e.p] = e.d;
      end
      chk("p0_gnt", p0_gnt, eg[0]);
      chk("p1_gnt", p1_gnt, eg[1]);
      chk("p0_rvalid", p0_rvalid, erv[0]);
      chk("p0_rdata", p0_rdata, erd[0]);
      chk("p1_rvalid", p1_rvalid, erv[1]);
      chk("p1_rdata", p1_rdata, erd[1]);
      any = |eg;
      g   = eg[1];
      we  = g ? p1_we : p0_we;
      a   = g ? p1_addr : p0_addr;
      d   = g ? p1_wdata : p0_wdata;
      chk("mem_read", mem_read, any & ~we);
      chk("mem_write", mem_write, any & we);
      chk("mem_addr", mem_addr, any ? a : '0);
      chk("mem_data_in", mem_data_in, (any & we) ? d : '0);
      if (any && we) ref_mem[a] = d;
      else if (any) begin
         e.p = g;
         e.d = ref_mem[a];
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i] = DW'(i * 29 + 17);
         ref_mem[i] = DW'(i * 29 + 17);
      end
      mem[5] = 8'h3C;
      ref_mem[5] = 8'h3C;
      set_p0(1, 0, 0, 5'd5, 8'h00);
      set_p1(1, 0, 0, 5'd9, 8'h00);
      step(2'b00);
      step(2'b00);
      rst_n = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
      repeat (6) step(2'b01);
`else
      for (int i = 0; i < 6; i++) step(i % 2 ? 2'b10 : 2'b01);
`endif
      set_p0(0, 0, 0, 5'd0, 8'h00);
      set_p1(0, 0, 0, 5'd0, 8'h00);
      step(2'b00);
      set_p0(1, 0, 0, 5'd5, 8'h00);
      step(2'b01);
      set_p0(0, 0, 0, 5'd0, 8'h00);
      step(2'b00);
      set_p0(1, 1, 0, 5'd3, 8'hA5);
      step(2'b01);
      set_p0(0, 0, 0, 5'd0, 8'h00);
      set_p1(1, 0, 0, 5'd3, 8'h00);
      step(2'b10);
      set_p1(0, 0, 0, 5'd0, 8'h00);
      step(2'b00);
      set_p0(1, 0, 0, 5'd7, 8'h00);
      set_p1(1, 0, 1, 5'd8, 8'h00);
`ifdef MEM_ARB_FIXED_PRIO_EN
      repeat (11) step(2'b01);
`else
      for (int i = 0; i < 11; i++) step(i % 5 == 0 ? 2'b01 : 2'b10);
`endif
      set_p0(0, 0, 0, 5'd0, 8'h00);
      set_p1(0, 0, 0, 5'd0, 8'h00);
      step(2'b00);
      set_p0(1, 0, 0, 5'd5, 8'h00);
      step(2'b01);
      rst_n = 1'b0;
      step(2'b00);
      rst_n = 1'b1;
      set_p1(1, 0, 0, 5'd2, 8'h00);
      step(2'b01);
      set_p0(0, 0, 0, 5'd0, 8'h00);
      step(2'b10);
      set_p1(0, 0, 0, 5'd0, 8'h00);
      step(2'b00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
